// File: rtl/spi_timer_pkg.sv
// Shared constants for the SPI timer arbiter: FSM state encodings and default widths.
package spi_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int CNT_W_DEF = 8;
   localparam int N_REQ_DEF = 4;

endpackage

// File: rtl/delay_counter.sv
// Loadable one-shot down-counter; holds at zero instead of wrapping.
module delay_counter
   import spi_timer_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin owner of a shared one-shot delay counter; grants, counts, then pulses done.
module timer_arbiter
   import spi_timer_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*CNT_W-1:0] delay,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic                   busy
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   state_t           state;
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] owner;
   logic [PTR_W-1:0] winner;
   logic [PTR_W-1:0] nxt_ptr;
   logic             found;
   logic             load;
   logic             zero;
   logic [CNT_W-1:0] load_val;

   // First set request at or after ptr, wrapping modulo N_REQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < N_REQ; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!found && req[j]) begin
            found  = 1'b1;
            winner = PTR_W'(j);
         end
      end
   end

   assign nxt_ptr  = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
   assign load     = (state == ST_IDLE) && found;
   assign load_val = delay[int'(winner)*CNT_W +: CNT_W];

   delay_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .en       (state == ST_COUNT),
      .zero     (zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         ptr   <= '0;
         owner <= '0;
         grant <= '0;
         done  <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (found) begin
                  state <= ST_COUNT;
                  owner <= winner;
                  ptr   <= nxt_ptr;
                  grant <= ONE << winner;
                  busy  <= 1'b1;
               end
            end
            ST_COUNT: begin
               if (zero) begin
                  state <= ST_DONE;
                  grant <= '0;
                  done  <= ONE << owner;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= '0;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               grant <= '0;
               done  <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter (N_REQ=4, CNT_W=8) with hand-computed cycle timing.
module tb_timer_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] delay;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;

   int total = 0;
   int bad   = 0;

   timer_arbiter #(.N_REQ(4), .CNT_W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .delay (delay),
      .grant (grant),
      .done  (done),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_delay(input int i, input logic [7:0] v);
      delay[i*8 +: 8] = v;
   endtask

   // Next edge must be the accept edge k; returns in the IDLE cycle k+d+3.
   task automatic serve(input int i, input int d, input logic [3:0] drop, input bit poke);
      logic [3:0] oh;
      oh = 4'b0001 << i;
      tick();
      for (int c = 0; c <= d; c++) begin
         chk("grant", {28'd0, grant}, {28'd0, oh});
         chk("busy_cnt", {31'd0, busy}, 32'd1);
         chk("done_cnt", {28'd0, done}, 32'd0);
         if (poke && c == 3) begin
            req[3] = 1'b1;
            set_delay(0, 8'd1);
         end
         tick();
      end
      chk("done", {28'd0, done}, {28'd0, oh});
      chk("grant_dn", {28'd0, grant}, 32'd0);
      chk("busy_dn", {31'd0, busy}, 32'd1);
      req = req & ~drop;
      tick();
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("grant_idle", {28'd0, grant}, 32'd0);
      chk("done_idle", {28'd0, done}, 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      req   = 4'b0000;
      delay = 32'd0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_grant", {28'd0, grant}, 32'd0);
      chk("rst_done", {28'd0, done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);

      // Single request, delay 5: ptr -> 3
      req = 4'b0100;
      set_delay(2, 8'd5);
      serve(2, 5, 4'b0100, 1'b0);

      // Zero delay: search from 3 finds 1
      req = 4'b0010;
      set_delay(1, 8'd0);
      serve(1, 0, 4'b0010, 1'b0);

      // Reset in the middle of a long count
      req = 4'b0100;
      set_delay(2, 8'd20);
      tick();
      tick();
      tick();
      chk("pre_rst_grant", {28'd0, grant}, 32'h4);
      req = 4'b0000;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("mid_rst_grant", {28'd0, grant}, 32'd0);
      chk("mid_rst_done", {28'd0, done}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("post_rst_done", {28'd0, done}, 32'd0);

      // Round robin with everyone requesting; ptr back at 0
      req   = 4'b1111;
      delay = {8'd2, 8'd2, 8'd2, 8'd2};
      serve(0, 2, 4'b0000, 1'b0);
      serve(1, 2, 4'b0000, 1'b0);
      serve(2, 2, 4'b0000, 1'b0);
      serve(3, 2, 4'b0000, 1'b0);
      serve(0, 2, 4'b1111, 1'b0);

      // Request and delay changes during COUNT are ignored; ptr=1 so 0 still wins
      req = 4'b0001;
      set_delay(0, 8'd10);
      set_delay(3, 8'd4);
      serve(0, 10, 4'b0001, 1'b1);
      serve(3, 4, 4'b1000, 1'b0);

      // Max delay, no wrap
      req = 4'b0010;
      set_delay(1, 8'd255);
      serve(1, 255, 4'b0010, 1'b0);
      tick();
      chk("final_done", {28'd0, done}, 32'd0);
      chk("final_busy", {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
